// File: rtl/modinv_pkg.sv
// Shared definitions for the modular-invertor helper blocks.
//   mode_e  : transform selector applied by the select/store copy engine
//   state_e : copy engine sequencing states
//   clog2() : width helper for elaborating select/address widths
package modinv_pkg;

  typedef enum logic [1:0] {
    MODE_COPY  = 2'b00,
    MODE_SHL1  = 2'b01,
    MODE_CLEAR = 2'b10,
    MODE_INV   = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_DRAIN = 2'b10
  } state_e;

  // Ceiling log2, evaluated at elaboration time only.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/modinv_helper_valid_pipe.sv
// Read-to-write alignment pipe for the select/store copy engine.
// Carries {valid, addr} DEPTH cycles so the write side sees each address in the
// same cycle the source RAM returns its data.
//   clk, rst  : clock, synchronous active-high reset (clears all valids)
//   vld_in    : a read is being issued this cycle
//   addr_in   : address of that read
//   vld_out   : data for addr_out is on the source bus this cycle
//   addr_out  : address whose data is currently valid
module modinv_helper_valid_pipe #(
  parameter int ADDR_BITS = 4,
  parameter int DEPTH     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 vld_in,
  input  logic [ADDR_BITS-1:0] addr_in,
  output logic                 vld_out,
  output logic [ADDR_BITS-1:0] addr_out
);

  logic [DEPTH-1:0]                vld_pipe;
  logic [DEPTH-1:0][ADDR_BITS-1:0] addr_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe[0]  <= vld_in;
      addr_pipe[0] <= addr_in;
      for (int i = 1; i < DEPTH; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  assign vld_out  = vld_pipe[DEPTH-1];
  assign addr_out = addr_pipe[DEPTH-1];

endmodule

// File: rtl/modinv_helper_select_store.sv
// Word-serial copy engine for the modular invertor. On a start strobe it reads
// NUM_WORDS words from the selected source buffer and writes a transformed copy
// (copy / shift-left-1 with carry chain / clear / invert) to the destination.
//   clk, rst   : clock, synchronous active-high reset (aborts any operation)
//   ena        : start strobe, honoured only while rdy
//   rdy        : idle / previous operation complete
//   sel        : source channel (out-of-range selects channel 0), latched at start
//   mode       : transform (see modinv_pkg::mode_e), latched at start
//   inhibit    : suppress destination writes, latched at start
//   src_addr   : shared source read address
//   src_din    : all source read buses, channel c at [c*WORD_W +: WORD_W]
//   dst_addr   : destination write address
//   dst_wren   : destination write enable
//   dst_dout   : destination write data
//   carry_out  : MSB shifted out by the most recent shl1 operation
module modinv_helper_select_store
  import modinv_pkg::*;
#(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 9,
  parameter int ADDR_BITS = 4,
  parameter int NUM_SRC   = 2,
  parameter int RD_LAT    = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ena,
  output logic                        rdy,
  input  logic [clog2(NUM_SRC)-1:0]   sel,
  input  logic [1:0]                  mode,
  input  logic                        inhibit,
  output logic [ADDR_BITS-1:0]        src_addr,
  input  logic [NUM_SRC*WORD_W-1:0]   src_din,
  output logic [ADDR_BITS-1:0]        dst_addr,
  output logic                        dst_wren,
  output logic [WORD_W-1:0]           dst_dout,
  output logic                        carry_out
);

  localparam int SEL_BITS = clog2(NUM_SRC);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_WORDS - 1);

  state_e              state;
  logic [SEL_BITS-1:0] sel_q;
  mode_e               mode_q;
  logic                inhibit_q;
  logic                carry_q;

  logic                 wr_vld;
  logic [ADDR_BITS-1:0] wr_addr;
  logic                 last_wr;
  logic [WORD_W-1:0]    src_word;
  logic [WORD_W-1:0]    xform_word;

  // Every READ cycle issues one read; the pipe re-times it to the data.
  modinv_helper_valid_pipe #(
    .ADDR_BITS (ADDR_BITS),
    .DEPTH     (RD_LAT)
  ) u_vpipe (
    .clk      (clk),
    .rst      (rst),
    .vld_in   (state == ST_READ),
    .addr_in  (src_addr),
    .vld_out  (wr_vld),
    .addr_out (wr_addr)
  );

  assign last_wr = wr_vld && (wr_addr == LAST_ADDR);
  assign rdy     = (state == ST_IDLE);

  always_comb begin
    src_word = src_din[int'(sel_q)*WORD_W +: WORD_W];
  end

  always_comb begin
    xform_word = src_word;
    case (mode_q)
      MODE_COPY:  xform_word = src_word;
      MODE_SHL1:  xform_word = {src_word[WORD_W-2:0], carry_q};
      MODE_CLEAR: xform_word = '0;
      MODE_INV:   xform_word = ~src_word;
      default:    xform_word = src_word;
    endcase
  end

  assign dst_dout = xform_word;
  assign dst_wren = wr_vld && !inhibit_q;
  assign dst_addr = wr_vld ? wr_addr : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      src_addr  <= '0;
      sel_q     <= '0;
      mode_q    <= MODE_COPY;
      inhibit_q <= 1'b0;
      carry_q   <= 1'b0;
      carry_out <= 1'b0;
    end else begin
      // Carry chain follows every written word; only shl1 consumes it.
      if (wr_vld) carry_q <= src_word[WORD_W-1];

      case (state)
        ST_IDLE: begin
          src_addr <= '0;
          if (ena) begin
            state     <= ST_READ;
            sel_q     <= (int'(sel) < NUM_SRC) ? sel : '0;
            mode_q    <= mode_e'(mode);
            inhibit_q <= inhibit;
            carry_q   <= 1'b0;
          end
        end
        ST_READ: begin
          if (src_addr == LAST_ADDR) begin
            src_addr <= '0;
            state    <= ST_DRAIN;
          end else begin
            src_addr <= src_addr + ADDR_BITS'(1);
          end
        end
        ST_DRAIN: begin
          if (last_wr) begin
            state <= ST_IDLE;
            // The MSW's top bit is the final carry of the chain.
            if (mode_q == MODE_SHL1) carry_out <= src_word[WORD_W-1];
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modinv_helper_select_store.sv
// Self-checking bench for modinv_helper_select_store (RD_LAT=3, NUM_SRC=3 so the
// deep read pipe and the out-of-range select fallback are both exercised).
module tb_modinv_helper_select_store;

  localparam int W  = 32;
  localparam int NW = 9;
  localparam int AB = 4;
  localparam int NS = 3;
  localparam int RL = 3;
  localparam int SB = 2;

  logic          clk = 1'b0;
  logic          rst, ena, rdy, inhibit, dst_wren, carry_out;
  logic [SB-1:0] sel;
  logic [1:0]    mode;
  logic [AB-1:0] src_addr, dst_addr;
  logic [NS*W-1:0] src_din;
  logic [W-1:0]  dst_dout;

  int   checks = 0;
  int   errors = 0;
  logic carry_exp = 1'b0;

  logic [W-1:0]    mem [NS][NW];
  logic [NS*W-1:0] rd_pipe [RL];

  always #5 clk = ~clk;

  modinv_helper_select_store #(
    .WORD_W(W), .NUM_WORDS(NW), .ADDR_BITS(AB), .NUM_SRC(NS), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .rdy(rdy), .sel(sel), .mode(mode),
    .inhibit(inhibit), .src_addr(src_addr), .src_din(src_din),
    .dst_addr(dst_addr), .dst_wren(dst_wren), .dst_dout(dst_dout),
    .carry_out(carry_out)
  );

  // Source RAMs: RL-cycle registered read latency.
  always @(posedge clk) begin
    for (int c = 0; c < NS; c++) rd_pipe[0][c*W +: W] <= mem[c][int'(src_addr)];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign src_din = rd_pipe[RL-1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation, called at a negedge while idle. Expected words come
  // from the transform rules applied to the RAM image; timing from RL/NW.
  task automatic run_op(input logic [SB-1:0] s, input logic [1:0] m, input logic inh,
                        input bit hold_ena, input bit scramble);
    logic [W-1:0] exp_w [NW];
    logic [W-1:0] w;
    int ch, k;
    logic c, wr;
    ch = (int'(s) < NS) ? int'(s) : 0;
    c  = 1'b0;
    for (int i = 0; i < NW; i++) begin
      w = mem[ch][i];
      case (m)
        2'd0: exp_w[i] = w;
        2'd1: begin exp_w[i] = {w[W-2:0], c}; c = w[W-1]; end
        2'd2: exp_w[i] = '0;
        default: exp_w[i] = ~w;
      endcase
    end
    chk("start_rdy", 64'(rdy), 64'(1));
    sel = s; mode = m; inhibit = inh; ena = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= NW + RL + 1; n++) begin
      @(negedge clk);
      if (n == 1) begin
        ena = hold_ena;
        if (scramble) begin
          sel     = SB'($urandom_range(0, 3));
          mode    = 2'($urandom_range(0, 3));
          inhibit = 1'($urandom_range(0, 1));
        end
      end
      wr = (n >= RL + 1) && (n <= NW + RL);
      k  = n - RL - 1;
      chk("rdy", 64'(rdy), 64'(n == NW + RL + 1));
      chk("src_addr", 64'(src_addr), (n <= NW) ? 64'(n - 1) : 64'(0));
      chk("dst_wren", 64'(dst_wren), 64'(wr && !inh));
      if (wr) begin
        chk("dst_addr", 64'(dst_addr), 64'(k));
        chk("dst_dout", 64'(dst_dout), 64'(exp_w[k]));
      end else begin
        chk("dst_addr_idle", 64'(dst_addr), 64'(0));
      end
    end
    if (m == 2'd1) carry_exp = c;
    chk("carry_out", 64'(carry_out), 64'(carry_exp));
  endtask

  initial begin
    rst = 1'b1; ena = 1'b0; sel = '0; mode = '0; inhibit = 1'b0;
    for (int c = 0; c < NS; c++)
      for (int k = 0; k < NW; k++) mem[c][k] = $urandom;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", 64'(rdy), 64'(1));
    chk("rst_src_addr", 64'(src_addr), 64'(0));
    chk("rst_dst_addr", 64'(dst_addr), 64'(0));
    chk("rst_dst_wren", 64'(dst_wren), 64'(0));
    chk("rst_carry", 64'(carry_out), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // copy from channel 1, v[k] = 0x1000+k
    for (int k = 0; k < NW; k++) mem[1][k] = 32'h1000 + 32'(k);
    run_op(2'd1, 2'd0, 1'b0, 0, 0);

    // shl1 carry chain across words, channel 0
    mem[0][0] = 32'h8000_0001;
    for (int k = 1; k < NW; k++) mem[0][k] = 32'h8000_0000;
    run_op(2'd0, 2'd1, 1'b0, 0, 0);
    chk("shl1_carry_one", 64'(carry_out), 64'(1));

    // inhibited invert: no writes, carry held
    run_op(2'd2, 2'd3, 1'b1, 0, 0);
    // clear from channel 2
    run_op(2'd2, 2'd2, 1'b0, 0, 0);
    // out-of-range select falls back to channel 0
    run_op(2'd3, 2'd0, 1'b0, 0, 0);

    // reset asserted in cycle 5 of an shl1 operation
    sel = 2'd1; mode = 2'd1; inhibit = 1'b0; ena = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      ena = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    carry_exp = 1'b0;
    chk("abort_rdy", 64'(rdy), 64'(1));
    chk("abort_src_addr", 64'(src_addr), 64'(0));
    chk("abort_carry", 64'(carry_out), 64'(0));
    for (int n = 0; n < 2 * RL + 4; n++) begin
      chk("abort_no_wren", 64'(dst_wren), 64'(0));
      @(negedge clk);
    end
    run_op(2'd1, 2'd0, 1'b0, 0, 0);

    // back-to-back random operations with mid-op input scrambling
    for (int c = 0; c < NS; c++)
      for (int k = 0; k < NW; k++) mem[c][k] = $urandom;
    for (int i = 0; i < 8; i++)
      run_op(SB'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), (i != 7), 1);

    // a few spaced random operations with fresh data
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < NS; c++)
        for (int k = 0; k < NW; k++) mem[c][k] = $urandom;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      run_op(SB'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
